// File: rtl/icache_tag_ctrl_nway.sv
// N-way instruction-cache tag controller: tag RAM with power-up invalidation sweep,
// per-set tree-PLRU in flops, two-stage lookup (S0 read, S1 compare/respond/update).
module icache_tag_ctrl_nway #(
  parameter int WAY_NUM     = 4,
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_vld,
  output logic                   req_rdy,
  input  logic [1:0]             req_opcode,
  input  logic [INDEX_WIDTH-1:0] req_index,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  input  logic                   stall,
  output logic                   rsp_vld,
  output logic                   rsp_hit,
  output logic [WAY_NUM-1:0]     rsp_hit_way,
  output logic [WAY_NUM-1:0]     rsp_victim_way,
  output logic                   init_done
);

  localparam int WAY_LOG = $clog2(WAY_NUM);
  localparam int SETS    = 1 << INDEX_WIDTH;
  localparam int ENTRY_W = TAG_WIDTH + 1;
  localparam int ROW_W   = WAY_NUM * ENTRY_W;
  localparam int NODES   = WAY_NUM - 1;

  localparam logic [1:0] OP_SNOOP = 2'b10;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  // Tree nodes are heap-ordered: node n has children 2n+1 (lower) and 2n+2 (upper).
  function automatic logic [WAY_NUM-1:0] plru_victim(input logic [NODES-1:0] bits);
    int              node;
    logic [NODES-1:0] sh;
    node = 0;
    for (int l = 0; l < WAY_LOG; l++) begin
      sh   = bits >> node;
      node = 2 * node + 1 + (sh[0] ? 1 : 0);
    end
    return WAY_NUM'(1) << (node - NODES);
  endfunction

  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                  input logic [WAY_NUM-1:0] way);
    int               wi;
    int               node;
    int               dir;
    logic [NODES-1:0] mask;
    logic [NODES-1:0] res;
    wi  = 0;
    res = bits;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (way[w]) wi = w;
    end
    node = 0;
    for (int l = 0; l < WAY_LOG; l++) begin
      dir  = (wi >> (WAY_LOG - 1 - l)) & 1;
      mask = NODES'(1) << node;
      if (dir == 0) res = res | mask;
      else          res = res & ~mask;
      node = 2 * node + 1 + dir;
    end
    return res;
  endfunction

  state_e                 state_q;
  logic [INDEX_WIDTH-1:0] init_idx_q;
  logic                   init_done_q;

  logic [ROW_W-1:0]       mem [SETS];
  logic [ROW_W-1:0]       rdata_q;
  logic [NODES-1:0]       plru_q [SETS];

  logic                   s1_vld_q, s1_vld_d;
  logic [1:0]             s1_op_q, s1_op_d;
  logic [INDEX_WIDTH-1:0] s1_idx_q, s1_idx_d;
  logic [TAG_WIDTH-1:0]   s1_tag_q, s1_tag_d;

  logic                   accept;
  logic [WAY_NUM-1:0]     hit_way, valid_vec, inv_way, victim;
  logic                   s1_hit, fill_op, snoop_op, s1_wr_en, plru_we;
  logic [NODES-1:0]       plru_cur, plru_row;
  logic [ROW_W-1:0]       wr_row;
  logic                   ram_we;
  logic [INDEX_WIDTH-1:0] ram_waddr;
  logic [ROW_W-1:0]       ram_wdata;

  // Sweep walks every set once and parks on the last index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (init_idx_q == '1) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            init_idx_q <= init_idx_q + 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign init_done = init_done_q;
  assign req_rdy   = (state_q == ST_RUN) && !stall && !s1_wr_en;
  assign accept    = req_vld && req_rdy;

  always_comb begin
    s1_vld_d = accept;
    s1_op_d  = s1_op_q;
    s1_idx_d = s1_idx_q;
    s1_tag_d = s1_tag_q;
    if (accept) begin
      s1_op_d  = req_opcode;
      s1_idx_d = req_index;
      s1_tag_d = req_tag;
    end
  end

  // S0 -> S1 boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_vld_q <= 1'b0;
    else        s1_vld_q <= s1_vld_d;
  end

  always_ff @(posedge clk) begin
    s1_op_q  <= s1_op_d;
    s1_idx_q <= s1_idx_d;
    s1_tag_q <= s1_tag_d;
  end

  // Single-port RAM: writes only happen while acceptance is blocked, so no collision.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (accept) rdata_q <= mem[req_index];
  end

  always_comb begin
    hit_way   = '0;
    valid_vec = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      valid_vec[w] = rdata_q[w*ENTRY_W + TAG_WIDTH];
      if (valid_vec[w] && (rdata_q[w*ENTRY_W +: TAG_WIDTH] == s1_tag_q)) hit_way[w] = 1'b1;
    end
    inv_way = '0;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (!valid_vec[w]) inv_way = WAY_NUM'(1) << w;
    end
    s1_hit   = |hit_way;
    fill_op  = !s1_op_q[1];
    snoop_op = (s1_op_q == OP_SNOOP);
    plru_cur = plru_q[s1_idx_q];
    victim   = (|inv_way) ? inv_way : plru_victim(plru_cur);
    s1_wr_en = s1_vld_q && ((fill_op && !s1_hit) || (snoop_op && s1_hit));
    wr_row   = rdata_q;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (fill_op && victim[w])   wr_row[w*ENTRY_W +: ENTRY_W] = {1'b1, s1_tag_q};
      if (snoop_op && hit_way[w]) wr_row[w*ENTRY_W + TAG_WIDTH] = 1'b0;
    end
    plru_we  = s1_vld_q && fill_op;
    plru_row = plru_touch(plru_cur, s1_hit ? hit_way : victim);
  end

  always_comb begin
    ram_we    = s1_wr_en;
    ram_waddr = s1_idx_q;
    ram_wdata = wr_row;
    if (state_q == ST_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = init_idx_q;
      ram_wdata = '0;
    end
  end

  // S1 update boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (plru_we) begin
      plru_q[s1_idx_q] <= plru_row;
    end
  end

  assign rsp_vld        = s1_vld_q;
  assign rsp_hit        = s1_vld_q && s1_hit;
  assign rsp_hit_way    = s1_vld_q ? hit_way : '0;
  assign rsp_victim_way = (s1_vld_q && fill_op && !s1_hit) ? victim : '0;

endmodule
